// File: rtl/atahost_pio_sequencer.sv
// PIO transfer sequencer for the OCIDEC ATA host: runs one 16-bit register access through T1/T2/T4/Teoc.
// Optional macro ATAHOST_IORDY_SYNC_EN adds a two-flop synchronizer on iordy_pad_i.
module atahost_pio_sequencer #(
    parameter int TWIDTH = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [TWIDTH-1:0] t1,
    input  logic [TWIDTH-1:0] t2,
    input  logic [TWIDTH-1:0] t4,
    input  logic [TWIDTH-1:0] teoc,
    input  logic              iordy_en,
    input  logic              req,
    input  logic              we,
    input  logic [3:0]        a,
    input  logic [15:0]       d,
    output logic              ack,
    output logic [15:0]       q,
    output logic              busy,
    output logic [2:0]        da_pad_o,
    output logic              cs0n_pad_o,
    output logic              cs1n_pad_o,
    output logic              diorn_pad_o,
    output logic              diown_pad_o,
    output logic [15:0]       dd_pad_o,
    output logic              dd_padoe_o,
    input  logic [15:0]       dd_pad_i,
    input  logic              iordy_pad_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T4   = 3'd3,
        ST_TEOC = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TWIDTH-1:0]   cnt_q, cnt_d;
    logic [TWIDTH-1:0]   t2_q, t2_d, t4_q, t4_d, teoc_q, teoc_d;
    logic                we_q, we_d;
    logic [3:0]          a_q, a_d;
    logic [15:0]         d_q, d_d;
    logic [15:0]         q_q, q_d;
    logic                cs0n_q, cs0n_d, cs1n_q, cs1n_d;
    logic                diorn_q, diorn_d, diown_q, diown_d;
    logic [2:0]          da_q, da_d;
    logic [15:0]         dd_q, dd_d;
    logic                ddoe_q, ddoe_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                cnt_zero_s;
    logic                phase_act_s;
    logic                iordy_s;

`ifdef ATAHOST_IORDY_SYNC_EN
    logic [1:0] iordy_sync_q, iordy_sync_d;

    // Two-stage synchronizer; idles at 1 so a reset never looks like a wait request
    always_comb begin
        iordy_sync_d = {iordy_sync_q[0], iordy_pad_i};
    end

    // Synchronizer flops
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            iordy_sync_q <= 2'b11;
        end else begin
            iordy_sync_q <= iordy_sync_d;
        end
    end

    assign iordy_s = iordy_sync_q[1];
`else
    assign iordy_s = iordy_pad_i;
`endif

    assign cnt_zero_s = (cnt_q == {TWIDTH{1'b0}});

    // Next-state, phase counter, request latching and read capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t2_d    = t2_q;
        t4_d    = t4_q;
        teoc_d  = teoc_q;
        we_d    = we_q;
        a_d     = a_q;
        d_d     = d_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_T1;
                    cnt_d   = t1;
                    t2_d    = t2;
                    t4_d    = t4;
                    teoc_d  = teoc;
                    we_d    = we;
                    a_d     = a;
                    d_d     = d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T1: begin
                if (cnt_zero_s) begin
                    state_d = ST_T2;
                    cnt_d   = t2_q;
                end else begin
                    cnt_d = cnt_q - {{(TWIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_T2: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - {{(TWIDTH-1){1'b0}}, 1'b1};
                end else if (iordy_en && !iordy_s) begin
                    // Device is stretching the strobe: hold with the counter parked at 0
                    cnt_d = {TWIDTH{1'b0}};
                end else begin
                    state_d = ST_T4;
                    cnt_d   = t4_q;
                    if (!we_q) begin
                        q_d = dd_pad_i;
                    end else begin
                        q_d = q_q;
                    end
                end
            end
            ST_T4: begin
                if (cnt_zero_s) begin
                    state_d = ST_TEOC;
                    cnt_d   = teoc_q;
                end else begin
                    cnt_d = cnt_q - {{(TWIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_TEOC: begin
                if (cnt_zero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(TWIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {TWIDTH{1'b0}};
            end
        endcase
    end

    // Pad outputs are decoded from the next state so they are registered alongside it
    always_comb begin
        phase_act_s = (state_d == ST_T1) || (state_d == ST_T2) || (state_d == ST_T4);
        cs0n_d      = !(phase_act_s && !a_d[3]);
        cs1n_d      = !(phase_act_s && a_d[3]);
        da_d        = phase_act_s ? a_d[2:0] : 3'b000;
        ddoe_d      = phase_act_s && we_d;
        dd_d        = ddoe_d ? d_d : 16'h0000;
        diown_d     = !((state_d == ST_T2) && we_d);
        diorn_d     = !((state_d == ST_T2) && !we_d);
        ack_d       = (state_q == ST_T4) && (state_d == ST_TEOC);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, counter, latched request and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {TWIDTH{1'b0}};
            t2_q    <= {TWIDTH{1'b0}};
            t4_q    <= {TWIDTH{1'b0}};
            teoc_q  <= {TWIDTH{1'b0}};
            we_q    <= 1'b0;
            a_q     <= 4'h0;
            d_q     <= 16'h0000;
            q_q     <= 16'h0000;
            cs0n_q  <= 1'b1;
            cs1n_q  <= 1'b1;
            diorn_q <= 1'b1;
            diown_q <= 1'b1;
            da_q    <= 3'b000;
            dd_q    <= 16'h0000;
            ddoe_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t2_q    <= t2_d;
            t4_q    <= t4_d;
            teoc_q  <= teoc_d;
            we_q    <= we_d;
            a_q     <= a_d;
            d_q     <= d_d;
            q_q     <= q_d;
            cs0n_q  <= cs0n_d;
            cs1n_q  <= cs1n_d;
            diorn_q <= diorn_d;
            diown_q <= diown_d;
            da_q    <= da_d;
            dd_q    <= dd_d;
            ddoe_q  <= ddoe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack         = ack_q;
    assign q           = q_q;
    assign busy        = busy_q;
    assign da_pad_o    = da_q;
    assign cs0n_pad_o  = cs0n_q;
    assign cs1n_pad_o  = cs1n_q;
    assign diorn_pad_o = diorn_q;
    assign diown_pad_o = diown_q;
    assign dd_pad_o    = dd_q;
    assign dd_padoe_o  = ddoe_q;

endmodule

// File: doc/atahost_pio_sequencer.md
# atahost_pio_sequencer

PIO transfer sequencer for the OCIDEC ATA host. Accepts single 16-bit register read/write requests from the WISHBONE-side register decoder and drives the ATA bus strobes, address, chip selects and data through the PIO-compatible T1/T2/T4/Teoc phases, with optional IORDY wait-state stretching. It sits between the host top level, which supplies timing registers and requests, and the ATA pads.

## Interface
- TWIDTH, 8, width of timing inputs and phase counter.
- wb_clk_i  in  1  master clock.
- wb_rst_i  in  1  synchronous reset, active-high.
- t1, t2, t4, teoc  in  TWIDTH each  phase lengths in cycles minus one.
- iordy_en  in  1  enables IORDY stretching of T2.
- req  in  1  transfer request; level, held until ack.
- we  in  1  1 = write, 0 = read.
- a  in  4  a[3]=1 selects CS1n, else CS0n; a[2:0] = DA.
- d  in  16  write data.
- ack  out  1  one-cycle completion pulse.
- q  out  16  read data.
- busy  out  1  high whenever not IDLE.
- da_pad_o  out  3; cs0n_pad_o, cs1n_pad_o, diorn_pad_o, diown_pad_o  out  1 each.
- dd_pad_o  out  16; dd_padoe_o  out  1; dd_pad_i  in  16; iordy_pad_i  in  1.

## Operation
- States: IDLE, T1, T2, T4, TEOC. One down-counter (TWIDTH bits); each phase loads its value and lasts value+1 cycles, so 0 gives 1 cycle.
- IDLE: req sampled at a rising edge → latch a, d, we, t1..teoc; go to T1. Timing inputs changed mid-transfer have no effect.
- T1: cs0n/cs1n, da driven from latched a. On a write, dd_pad_o=d and dd_padoe_o=1 from T1 through T4.
- T2: diown_pad_o (write) or diorn_pad_o (read) low. When the counter is 0, the phase ends unless iordy_en=1 and sampled IORDY=0, in which case T2 holds (counter stays 0) until IORDY=1. On leaving T2 during a read, q ← dd_pad_i.
- T4: strobes high; CS/DA/data still driven.
- TEOC: CS high, da=0, dd_padoe_o=0; ack=1 in the first TEOC cycle only; req ignored throughout TEOC; then IDLE.
- q holds its value until the next read capture.
- Reset values (also applied on the edge after wb_rst_i, from any state): state IDLE, diorn/diown/cs0n/cs1n=1, da=0, dd_pad_o=0, dd_padoe_o=0, ack=0, q=0, busy=0. A transfer aborted by reset never acks.

## Timing
- req sampled at edge 0 → T1 occupies cycles 1..t1+1.
- T2 (unstretched) occupies t2+1 cycles and T4 occupies t4+1 cycles.
- ack is high at cycle t1+t2+t4+4.
- IDLE is re-entered at cycle t1+t2+t4+teoc+5. A still-high req is accepted there, and the next T1 starts one cycle later.
- The minimum transfer takes 5 cycles with all timings 0. IORDY stretching adds exactly the number of cycles the sampled IORDY stays low after the T2 counter reaches 0.
- The WISHBONE master must drop req on the cycle after ack, or present a new request.

## Configuration
- ATAHOST_IORDY_SYNC_EN defined: iordy_pad_i passes through a two-flop synchronizer reset to 1, and T2 stretching reacts to IORDY changes 2 cycles late.
- Not defined: iordy_pad_i is sampled directly, with no added latency.

## Test plan
- Write: t1=2, t2=3, t4=1, teoc=2, a=4'b1110, d=16'hA55A → cs1n=0, da=6, dd_padoe_o=1 cycles 1..9; diown=0 cycles 4..7; ack at cycle 10; busy cycles 1..12.
- Read: all timings 0, a=4'b0111, dd_pad_i=16'h1234 → cs0n=0, da=7; diorn=0 cycle 2 only; ack cycle 4; q=16'h1234; dd_padoe_o stays 0.
- IORDY stretch: iordy_en=1, t2=1, IORDY low from T1 until 5 cycles after the T2 counter hits 0 → diorn low t2+1+5 cycles (+2 with ATAHOST_IORDY_SYNC_EN); ack delayed by 5 (or 7).
- IORDY disabled: iordy_en=0, IORDY held low → timing identical to the unstretched case.
- Back-to-back: req held high through ack (scenario-1 timings) → second T1 starts at cycle 14; no gap or overlap of CS.
- Reset mid-T2 of a write → next cycle all outputs at reset values, no ack; a following request runs normally.
